// File: rtl/rgb2gray_if.sv
// Pixel stream bundle for rgb2gray: RGB888 input side with timing strobes and the gray output side.
// The master drives RGB and receives gray; the converter uses the slave modport.
interface rgb2gray_if;
    logic       rgb_valid;
    logic       rgb_hsync;
    logic       rgb_vsync;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] gray;
    logic       gray_valid;
    logic       gray_hsync;
    logic       gray_vsync;

    modport master (
        output rgb_valid, rgb_hsync, rgb_vsync, r, g, b,
        input  gray, gray_valid, gray_hsync, gray_vsync
    );

    modport slave (
        input  rgb_valid, rgb_hsync, rgb_vsync, r, g, b,
        output gray, gray_valid, gray_hsync, gray_vsync
    );
endinterface

// File: rtl/rgb2gray.sv
// RGB888 to 8-bit luminance converter, one pixel per clock, 1-cycle latency.
// METHOD picks "WEIGHT" (default) or "AVERAGE"; define RGB2GRAY_ROUND_EN for round-to-nearest.
module rgb2gray #(
    parameter string METHOD = "WEIGHT"
) (
    input  logic      clk,
    input  logic      rst_n,
    rgb2gray_if.slave pix_if
);
    localparam int unsigned PIX_W = 8;
    localparam int unsigned SUM_W = 16;
    localparam int unsigned S3_W  = 10;
    localparam int unsigned P_W   = 18;

    logic [PIX_W-1:0] gray_c;
    logic [PIX_W-1:0] gray_d, gray_q;
    logic             valid_d, valid_q;
    logic             hsync_d, hsync_q;
    logic             vsync_d, vsync_q;

    generate
        if (METHOD == "AVERAGE") begin : g_avg
            logic [S3_W-1:0] s3;
            logic [P_W-1:0]  p;

            // 171/512 approximates 1/3
            assign s3 = S3_W'(pix_if.r) + S3_W'(pix_if.g) + S3_W'(pix_if.b);
            assign p  = P_W'(s3) * P_W'(171);
`ifdef RGB2GRAY_ROUND_EN
            logic [P_W-1:0] q;
            assign q      = (p + P_W'(256)) >> 9;
            assign gray_c = (q > P_W'(255)) ? PIX_W'(255) : PIX_W'(q);
`else
            assign gray_c = PIX_W'(p >> 9);
`endif
        end else begin : g_wgt
            logic [SUM_W-1:0] sum_w;

            // weights sum to 256, so the top byte is the luminance
            assign sum_w = SUM_W'(77)  * SUM_W'(pix_if.r)
                         + SUM_W'(150) * SUM_W'(pix_if.g)
                         + SUM_W'(29)  * SUM_W'(pix_if.b);
`ifdef RGB2GRAY_ROUND_EN
            assign gray_c = PIX_W'((sum_w + SUM_W'(128)) >> 8);
`else
            assign gray_c = PIX_W'(sum_w >> 8);
`endif
        end
    endgenerate

    // gray holds on invalid pixels; strobes are plain delays
    always_comb begin
        gray_d  = gray_q;
        valid_d = pix_if.rgb_valid;
        hsync_d = pix_if.rgb_hsync;
        vsync_d = pix_if.rgb_vsync;
        if (pix_if.rgb_valid) begin
            gray_d = gray_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_q  <= '0;
            valid_q <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            gray_q  <= gray_d;
            valid_q <= valid_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign pix_if.gray       = gray_q;
    assign pix_if.gray_valid = valid_q;
    assign pix_if.gray_hsync = hsync_q;
    assign pix_if.gray_vsync = vsync_q;
endmodule

// File: tb/tb_rgb2gray.sv
// Self-checking bench for rgb2gray: WEIGHT and AVERAGE instances share one stimulus stream,
// expected outputs come from an integer model through a scoreboard queue.
module tb_rgb2gray;
    typedef struct packed {
        logic [7:0] gw;
        logic [7:0] ga;
        logic       v;
        logic       h;
        logic       s;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   run;
    logic [7:0] mw;
    logic [7:0] ma;
    exp_t q[$];

    rgb2gray_if w_if ();
    rgb2gray_if a_if ();

    rgb2gray u_wgt (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_if (w_if)
    );

    rgb2gray #(.METHOD("AVERAGE")) u_avg (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_if (a_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mdl_w(input int r, input int g, input int b);
        int s;
        s = 77 * r + 150 * g + 29 * b;
`ifdef RGB2GRAY_ROUND_EN
        s = s + 128;
`endif
        return 8'(s / 256);
    endfunction

    function automatic logic [7:0] mdl_a(input int r, input int g, input int b);
        int p;
        int res;
        p = (r + g + b) * 171;
`ifdef RGB2GRAY_ROUND_EN
        res = (p + 256) / 512;
        if (res > 255) res = 255;
`else
        res = p / 512;
`endif
        return 8'(res);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gray_w"},  32'(w_if.gray), 32'd0);
        chk({tag, "_valid_w"}, 32'(w_if.gray_valid), 32'd0);
        chk({tag, "_hsync_w"}, 32'(w_if.gray_hsync), 32'd0);
        chk({tag, "_vsync_w"}, 32'(w_if.gray_vsync), 32'd0);
        chk({tag, "_gray_a"},  32'(a_if.gray), 32'd0);
        chk({tag, "_valid_a"}, 32'(a_if.gray_valid), 32'd0);
    endtask

    task automatic drive(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                         input logic v, input logic h, input logic s);
        w_if.r = rr; w_if.g = gg; w_if.b = bb;
        w_if.rgb_valid = v; w_if.rgb_hsync = h; w_if.rgb_vsync = s;
        a_if.r = rr; a_if.g = gg; a_if.b = bb;
        a_if.rgb_valid = v; a_if.rgb_hsync = h; a_if.rgb_vsync = s;
    endtask

    // drive one pixel, record its expectation, compare one cycle later
    task automatic step(input string tag, input logic [7:0] rr, input logic [7:0] gg,
                        input logic [7:0] bb, input logic v, input logic h, input logic s);
        exp_t e;
        @(negedge clk);
        drive(rr, gg, bb, v, h, s);
        if (v) begin
            mw = mdl_w(int'(rr), int'(gg), int'(bb));
            ma = mdl_a(int'(rr), int'(gg), int'(bb));
        end
        e = '{gw: mw, ga: ma, v: v, h: h, s: s};
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = q.pop_front();
            chk({tag, "_gray_w"}, 32'(w_if.gray), 32'(e.gw));
            chk({tag, "_gray_a"}, 32'(a_if.gray), 32'(e.ga));
            chk({tag, "_valid"},  32'(w_if.gray_valid), 32'(e.v));
            chk({tag, "_hsync"},  32'(w_if.gray_hsync), 32'(e.h));
            chk({tag, "_vsync"},  32'(w_if.gray_vsync), 32'(e.s));
            chk({tag, "_valid_a"}, 32'(a_if.gray_valid), 32'(e.v));
        end
        if (w_if.gray_valid) run++;
        else run = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        run    = 0;
        mw     = 8'h00;
        ma     = 8'h00;
        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(8'(i * 60 + 15), 8'hFF, 8'(i * 33), 1'b1, 1'(i), 1'(~i));
            @(posedge clk);
            #1;
            chk_zero("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;

        step("white", 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
`ifndef RGB2GRAY_ROUND_EN
        chk("white_lit_w", 32'(w_if.gray), 32'h00FF);
        chk("white_lit_a", 32'(a_if.gray), 32'h00FF);
`endif

        // primaries back-to-back
        step("red",   8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
`ifndef RGB2GRAY_ROUND_EN
        chk("red_lit", 32'(w_if.gray), 32'h004C);
`endif
        step("green", 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
`ifndef RGB2GRAY_ROUND_EN
        chk("green_lit", 32'(w_if.gray), 32'h0095);
`endif
        step("blue",  8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
`ifndef RGB2GRAY_ROUND_EN
        chk("blue_lit", 32'(w_if.gray), 32'h001C);
`endif
        step("black", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        step("avgvec", 8'h1E, 8'h3C, 8'h5A, 1'b1, 1'b0, 1'b0);
`ifndef RGB2GRAY_ROUND_EN
        chk("avgvec_lit", 32'(a_if.gray), 32'h003C);
`endif

        // valid drop for 3 cycles: gray holds, gray_valid low
        step("pre_hold", 8'h80, 8'h40, 8'hC0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("hold", 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
        end
        step("post_hold", 8'h12, 8'hEE, 8'h07, 1'b1, 1'b0, 1'b0);

        // full random frame
        run = 0;
        for (int y = 0; y < 200; y++) begin
            for (int x = 0; x < 200; x++) begin
                step("frame", 8'($urandom), 8'($urandom), 8'($urandom),
                     1'b1, 1'(x == 0), 1'(y == 0));
            end
        end
        chk("frame_valid_run", 32'(run), 32'd40000);
        step("frame_end", 8'h55, 8'h55, 8'h55, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-stream discards the in-flight pixel
        step("pre_rst", 8'hA0, 8'hB0, 8'hC0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        drive(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        chk_zero("rst_inflight");
        mw = 8'h00;
        ma = 8'h00;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step("after_rst", 8'h30, 8'h60, 8'h90, 1'b1, 1'b0, 1'b0);
        step("after_rst2", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
